// File: rtl/shift_and_sub_div.sv
`default_nettype none
// ============================================================================
// Module   : shift_and_sub_div
// Purpose  : Sequential restoring unsigned divider, one quotient bit per clock,
//            start/busy/done handshake. Optional macro DIV_ZERO_DETECT_EN
//            short-circuits divide-by-zero and raises div_by_zero.
// Revision : 1.0 - initial release
// ============================================================================
module shift_and_sub_div #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

`ifdef DIV_ZERO_DETECT_EN
  localparam bit DZ_DETECT_EN = 1'b1;
`else
  localparam bit DZ_DETECT_EN = 1'b0;
`endif

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] m;
  logic [CNT_W-1:0] cnt;

  logic [WIDTH:0]   shifted;
  logic [WIDTH:0]   trial;
  logic [WIDTH-1:0] acc_next;
  logic [WIDTH-1:0] q_next;

  // The restored remainder is always below M, so only the shifted working
  // value needs the extra bit; the stored accumulator stays WIDTH bits.
  always_comb begin
    shifted  = {acc, q[WIDTH-1]};
    trial    = shifted - {1'b0, m};
    acc_next = trial[WIDTH] ? shifted[WIDTH-1:0] : trial[WIDTH-1:0];
    q_next   = {q[WIDTH-2:0], ~trial[WIDTH]};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      acc         <= '0;
      q           <= '0;
      m           <= '0;
      cnt         <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE, DONE: begin
          state <= IDLE;
          if (start) begin
            acc <= '0;
            q   <= dividend;
            m   <= divisor;
            cnt <= '0;
            if (DZ_DETECT_EN && (divisor == '0)) begin
              state       <= DONE;
              done        <= 1'b1;
              quotient    <= '1;
              remainder   <= dividend;
              div_by_zero <= 1'b1;
            end else begin
              state <= RUN;
              busy  <= 1'b1;
            end
          end
        end
        RUN: begin
          acc <= acc_next;
          q   <= q_next;
          cnt <= cnt + 1'b1;
          if (cnt == LAST_ITER) begin
            state       <= DONE;
            busy        <= 1'b0;
            done        <= 1'b1;
            quotient    <= q_next;
            remainder   <= acc_next;
            div_by_zero <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_shift_and_sub_div.sv
`default_nettype none
// ============================================================================
// Module   : tb_shift_and_sub_div
// Purpose  : Scoreboard bench for shift_and_sub_div at WIDTH=8 and WIDTH=16.
// Revision : 1.0 - initial release
// ============================================================================
module tb_shift_and_sub_div;

`ifdef DIV_ZERO_DETECT_EN
  localparam bit DZ = 1'b1;
`else
  localparam bit DZ = 1'b0;
`endif

  typedef struct {
    logic [15:0] q;
    logic [15:0] r;
    logic        dz;
    int          cyc;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start8 = 1'b0, start16 = 1'b0;
  logic [7:0]  dd8 = '0, dv8 = '0;
  logic [15:0] dd16 = '0, dv16 = '0;
  logic        busy8, done8, dz8, busy16, done16, dz16;
  logic [7:0]  quo8, rem8;
  logic [15:0] quo16, rem16;

  int   cyc = 0;
  int   checks = 0;
  int   passed = 0;
  exp_t sb8[$];
  exp_t sb16[$];

  shift_and_sub_div #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .start(start8), .dividend(dd8), .divisor(dv8),
    .busy(busy8), .done(done8), .quotient(quo8), .remainder(rem8),
    .div_by_zero(dz8)
  );

  shift_and_sub_div #(.WIDTH(16)) dut16 (
    .clk(clk), .rst(rst), .start(start16), .dividend(dd16), .divisor(dv16),
    .busy(busy16), .done(done16), .quotient(quo16), .remainder(rem16),
    .div_by_zero(dz16)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act === req) passed++;
    else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
  endtask

  // Reference: plain integer division; divide-by-zero yields all ones / dividend.
  function automatic exp_t model(input logic [15:0] a, input logic [15:0] b, input int w, input int issue_cyc);
    exp_t e;
    bit zero_short;
    zero_short = DZ && (b == 0);
    if (b == 0) begin
      e.q = 16'((32'd1 << w) - 1);
      e.r = a;
    end else begin
      e.q = a / b;
      e.r = a % b;
    end
    e.dz  = zero_short;
    e.cyc = issue_cyc + 1 + (zero_short ? 1 : w);
    return e;
  endfunction

  always @(negedge clk) begin
    if (!rst && done8) begin
      if (sb8.size() == 0) check("unexpected_done8", 1, 0);
      else begin
        exp_t e;
        e = sb8.pop_front();
        check("quotient8", quo8, e.q);
        check("remainder8", rem8, e.r);
        check("dz8", dz8, e.dz);
        check("done8_cycle", cyc, e.cyc);
      end
    end
    if (!rst && done16) begin
      if (sb16.size() == 0) check("unexpected_done16", 1, 0);
      else begin
        exp_t e;
        e = sb16.pop_front();
        check("quotient16", quo16, e.q);
        check("remainder16", rem16, e.r);
        check("dz16", dz16, e.dz);
        check("done16_cycle", cyc, e.cyc);
      end
    end
  end

  // Called at a negedge; the following posedge is the accepting edge.
  task automatic issue8(input logic [7:0] a, input logic [7:0] b);
    start8 = 1'b1; dd8 = a; dv8 = b;
    sb8.push_back(model(16'(a), 16'(b), 8, cyc));
  endtask

  task automatic issue16(input logic [15:0] a, input logic [15:0] b);
    start16 = 1'b1; dd16 = a; dv16 = b;
    sb16.push_back(model(a, b, 16, cyc));
  endtask

  task automatic wait_done8(output int busy_cycles);
    busy_cycles = 0;
    for (int i = 0; i < 40 && !done8; i++) begin
      if (busy8) busy_cycles++;
      @(negedge clk);
    end
    if (!done8) check("timeout8", 0, 1);
  endtask

  task automatic wait_done16(output int busy_cycles);
    busy_cycles = 0;
    for (int i = 0; i < 60 && !done16; i++) begin
      if (busy16) busy_cycles++;
      @(negedge clk);
    end
    if (!done16) check("timeout16", 0, 1);
  endtask

  task automatic run8(input logic [7:0] a, input logic [7:0] b);
    int bc;
    issue8(a, b);
    @(negedge clk); start8 = 1'b0; dd8 = ~a; dv8 = ~b;
    wait_done8(bc);
    check("busy8_cycles", bc, (DZ && b == 0) ? 0 : 8);
    @(negedge clk);
  endtask

  initial begin
    int bc;
    repeat (3) @(negedge clk);
    check("rst_busy", busy8, 0);
    check("rst_done", done8, 0);
    check("rst_quotient", quo8, 0);
    check("rst_remainder", rem8, 0);
    check("rst_dz", dz8, 0);
    rst = 1'b0;
    @(negedge clk);

    run8(8'd100, 8'd7);
    run8(8'd255, 8'd1);
    run8(8'd5,   8'd9);
    run8(8'd0,   8'd3);
    run8(8'd200, 8'd0);

    // Back-to-back start in DONE, with stray start pulses during RUN.
    issue8(8'd100, 8'd7);
    @(negedge clk); start8 = 1'b0;
    wait_done8(bc);
    issue8(8'd9, 8'd4);
    @(negedge clk); start8 = 1'b0;
    repeat (2) @(negedge clk);
    start8 = 1'b1; dd8 = 8'd1; dv8 = 8'd1;
    @(negedge clk); start8 = 1'b0;
    @(negedge clk); start8 = 1'b1;
    @(negedge clk); start8 = 1'b0;
    wait_done8(bc);
    @(negedge clk);

    // Reset during the 4th RUN cycle aborts the pending operation.
    issue8(8'd100, 8'd7);
    @(negedge clk); start8 = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    sb8.delete();
    @(negedge clk); rst = 1'b0;
    check("abort_busy", busy8, 0);
    check("abort_done", done8, 0);
    check("abort_quotient", quo8, 0);
    check("abort_remainder", rem8, 0);
    check("abort_dz", dz8, 0);
    repeat (12) @(negedge clk);
    run8(8'd50, 8'd6);

    // Results hold while the next operation runs.
    issue8(8'd5, 8'd9);
    @(negedge clk); start8 = 1'b0;
    repeat (3) @(negedge clk);
    check("hold_quotient", quo8, 8);
    check("hold_remainder", rem8, 2);
    wait_done8(bc);
    @(negedge clk);

    for (int n = 0; n < 1000; n++) begin
      logic [7:0] a, b;
      a = 8'($urandom);
      b = ($urandom_range(0, 7) == 0) ? 8'd0 : 8'($urandom_range(1, 255) >> $urandom_range(0, 7));
      if (b == 0 && $urandom_range(0, 1) == 1) b = 8'd1;
      issue8(a, b);
      @(negedge clk); start8 = 1'b0;
      wait_done8(bc);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end
    @(negedge clk);

    for (int n = 0; n < 1000; n++) begin
      logic [15:0] a, b;
      a = 16'($urandom);
      b = ($urandom_range(0, 7) == 0) ? 16'd0 : 16'($urandom_range(1, 65535) >> $urandom_range(0, 15));
      issue16(a, b);
      @(negedge clk); start16 = 1'b0;
      wait_done16(bc);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    repeat (25) @(negedge clk);
    check("pending8", sb8.size(), 0);
    check("pending16", sb16.size(), 0);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
`default_nettype wire
